// File: rtl/egress_arbiter.sv
// Egress port arbiter: round-robin grant of up to four ingress head packets into
// a one-deep output register with ready/valid backpressure and a delivered-packet counter.
module egress_arbiter #(
   parameter int N_SRC  = 4,
   parameter int DATA_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_SRC-1:0]        req_in,
   input  logic [N_SRC*DATA_W-1:0] data_in,
   output logic [N_SRC-1:0]        ack_out,
   output logic                    valid_out,
   output logic [DATA_W-1:0]       data_out,
   output logic [1:0]              src_out,
   input  logic                    ready_in,
   output logic [15:0]             pkt_count
);

   typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

   state_t            state_r;
   state_t            state_next_s;
   logic [1:0]        rr_ptr_r;
   logic [1:0]        cand_s;
   logic [1:0]        grant_idx_s;
   logic              grant_s;
   logic              load_en_s;
   logic              xfer_s;
   logic [DATA_W-1:0] data_r;
   logic [1:0]        src_r;
   logic [15:0]       count_r;

   assign valid_out = (state_r == ST_FULL);
   assign data_out  = data_r;
   assign src_out   = src_r;
   assign pkt_count = count_r;
   assign load_en_s = (state_r == ST_EMPTY) || ready_in;
   assign xfer_s    = (state_r == ST_FULL) && ready_in;

   // Cyclic priority scan from rr_ptr_r; later iterations (closer to the pointer) win.
   always_comb begin
      grant_s     = 1'b0;
      grant_idx_s = 2'd0;
      cand_s      = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand_s = rr_ptr_r + 2'(k);
         if (req_in[cand_s] && load_en_s && !rst) begin
            grant_s     = 1'b1;
            grant_idx_s = cand_s;
         end else begin
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // One-hot acknowledge of the granted source, held low during reset.
   always_comb begin
      ack_out = {N_SRC{1'b0}};
      if (grant_s) begin
         ack_out[grant_idx_s] = 1'b1;
      end else begin
         ack_out = {N_SRC{1'b0}};
      end
   end

   // Output register occupancy: a grant always refills, a transfer alone drains.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (grant_s) state_next_s = ST_FULL;
            else         state_next_s = ST_EMPTY;
         end
         ST_FULL: begin
            if (grant_s)       state_next_s = ST_FULL;
            else if (ready_in) state_next_s = ST_EMPTY;
            else               state_next_s = ST_FULL;
         end
         default: state_next_s = ST_EMPTY;
      endcase
   end

   // Occupancy state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_r <= ST_EMPTY;
      else     state_r <= state_next_s;
   end

   // Packet capture and pointer advance past the granted source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r   <= {DATA_W{1'b0}};
         src_r    <= 2'd0;
         rr_ptr_r <= 2'd0;
      end else if (grant_s) begin
         data_r   <= data_in[int'(grant_idx_s)*DATA_W +: DATA_W];
         src_r    <= grant_idx_s;
         rr_ptr_r <= grant_idx_s + 2'd1;
      end else begin
         data_r   <= data_r;
         src_r    <= src_r;
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Saturating count of packets handed downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                count_r <= 16'd0;
      else if (xfer_s && count_r != 16'hFFFF) count_r <= count_r + 16'd1;
      else                                    count_r <= count_r;
   end

endmodule

// File: tb/tb_egress_arbiter.sv
// Self-checking bench for egress_arbiter: directed table, hand sequences,
// randomized traffic against a queue-free arithmetic reference, and counter saturation.
module tb_egress_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_in;
   logic [63:0] data_in;
   logic [3:0]  ack_out;
   logic        valid_out;
   logic [15:0] data_out;
   logic [1:0]  src_out;
   logic        ready_in;
   logic [15:0] pkt_count;

   int n_pass   = 0;
   int n_checks = 0;

   logic [15:0] slice_val [4];
   logic [63:0] fixed_data;

   // reference model state
   bit          m_valid;
   logic [15:0] m_data;
   int          m_src;
   int          m_cnt;
   int          m_next;

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic [3:0] ack;
      logic       vld;
      logic [1:0] src;
      logic [15:0] cnt;
   } vec_t;
   vec_t tbl [11];

   egress_arbiter #(.N_SRC(4), .DATA_W(16)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
      .valid_out(valid_out), .data_out(data_out), .src_out(src_out),
      .ready_in(ready_in), .pkt_count(pkt_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // source with the smallest cyclic distance from the next-priority source
   function automatic int pick(input logic [3:0] rq, input int nxt);
      int best  = -1;
      int bestd = 4;
      for (int i = 0; i < 4; i++) begin
         if (rq[i] && ((i - nxt + 4) % 4) < bestd) begin
            bestd = (i - nxt + 4) % 4;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic mcycle(input logic [3:0] rq, input logic rd, input logic [63:0] dt);
      int g;
      bit ld;
      req_in = rq; ready_in = rd; data_in = dt;
      #1;
      ld = !m_valid || rd;
      g  = ld ? pick(rq, m_next) : -1;
      chk("rnd_ack", {28'd0, ack_out}, (g >= 0) ? (32'd1 << g) : 32'd0);
      @(posedge clk);
      if (m_valid && rd) m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      if (g >= 0) begin
         m_valid = 1'b1; m_data = dt[g*16 +: 16]; m_src = g; m_next = (g + 1) % 4;
      end else if (m_valid && rd) begin
         m_valid = 1'b0;
      end
      #1;
      chk("rnd_valid", {31'd0, valid_out}, {31'd0, m_valid});
      chk("rnd_src",   {30'd0, src_out}, m_src);
      chk("rnd_data",  {16'd0, data_out}, {16'd0, m_data});
      chk("rnd_count", {16'd0, pkt_count}, m_cnt);
   endtask

   initial begin
      slice_val[0] = 16'h1111; slice_val[1] = 16'h2222;
      slice_val[2] = 16'hA5A5; slice_val[3] = 16'h4444;
      fixed_data = {slice_val[3], slice_val[2], slice_val[1], slice_val[0]};
      //            req      rdy   ack      vld   src    cnt
      tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd0};
      tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 16'd1};
      tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 16'd1};
      tbl[3]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 16'd2};
      tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd2};
      tbl[5]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'd2};
      tbl[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 16'd3};
      tbl[7]  = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 16'd4};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'd5};
      tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'd5};
      tbl[10] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 16'd5};

      rst = 1'b1; req_in = 4'b1111; ready_in = 1'b0; data_in = fixed_data;
      #12;
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_data",  {16'd0, data_out}, 32'd0);
      chk("rst_src",   {30'd0, src_out}, 32'd0);
      chk("rst_count", {16'd0, pkt_count}, 32'd0);
      chk("rst_ack",   {28'd0, ack_out}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         req_in = tbl[i].req; ready_in = tbl[i].rdy;
         #1;
         chk("tbl_ack", {28'd0, ack_out}, {28'd0, tbl[i].ack});
         @(posedge clk); #1;
         chk("tbl_valid", {31'd0, valid_out}, {31'd0, tbl[i].vld});
         chk("tbl_src",   {30'd0, src_out}, {30'd0, tbl[i].src});
         chk("tbl_data",  {16'd0, data_out}, {16'd0, slice_val[tbl[i].src]});
         chk("tbl_count", {16'd0, pkt_count}, {16'd0, tbl[i].cnt});
      end

      // asynchronous reset while holding a packet with five delivered
      req_in = 4'b1111; ready_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, valid_out}, 32'd0);
      chk("midrst_count", {16'd0, pkt_count}, 32'd0);
      chk("midrst_data",  {16'd0, data_out}, 32'd0);
      chk("midrst_src",   {30'd0, src_out}, 32'd0);
      chk("midrst_ack",   {28'd0, ack_out}, 32'd0);
      #1 rst = 1'b0; ready_in = 1'b1;
      #1;
      chk("post_rst_ack", {28'd0, ack_out}, 32'd1);
      @(posedge clk); #1;
      chk("post_rst_src", {30'd0, src_out}, 32'd0);
      chk("post_rst_data", {16'd0, data_out}, {16'd0, slice_val[0]});

      // all sources requesting: strict rotation with no idle cycle
      for (int k = 1; k <= 5; k++) begin
         chk("fair_ack", {28'd0, ack_out}, 32'd1 << (k % 4));
         @(posedge clk); #1;
         chk("fair_src",   {30'd0, src_out}, k % 4);
         chk("fair_valid", {31'd0, valid_out}, 32'd1);
      end

      // backpressure holds the register and suppresses acks
      req_in = 4'b0001; ready_in = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("bp_ack", {28'd0, ack_out}, 32'd0);
         @(posedge clk); #1;
         chk("bp_data",  {16'd0, data_out}, {16'd0, slice_val[1]});
         chk("bp_valid", {31'd0, valid_out}, 32'd1);
      end
      ready_in = 1'b1;
      #1;
      chk("bp_release_ack", {28'd0, ack_out}, 32'd1);
      @(posedge clk); #1;
      chk("bp_release_src",  {30'd0, src_out}, 32'd0);
      chk("bp_release_data", {16'd0, data_out}, {16'd0, slice_val[0]});

      // randomized traffic against the reference model
      rst = 1'b1; #1 rst = 1'b0;
      m_valid = 1'b0; m_data = 16'd0; m_src = 0; m_cnt = 0; m_next = 0;
      for (int k = 0; k < 400; k++) begin
         mcycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                {$urandom, $urandom});
      end

      // counter saturation under continuous traffic
      for (int k = 0; k < 65545; k++) mcycle(4'b1111, 1'b1, fixed_data);
      chk("sat_reached", {16'd0, pkt_count}, 32'h0000FFFF);
      for (int k = 0; k < 5; k++) mcycle(4'b1111, 1'b1, fixed_data);
      chk("sat_hold", {16'd0, pkt_count}, 32'h0000FFFF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
